rs_syndrome_calc: RTL and testbench

- Syndrome computation stage for the GF(2^5) RS(31,k) decoder; sits directly upstream of the key-equation solver.
- Accepts received codeword symbols serially, highest-degree coefficient first (r30 first, r0 last).
- Evaluates S_j = r(alpha^j) for j = 1..NSYN by Horner's rule, using a gfadder and a constant-alpha^j lcpmult per syndrome.
- Hands the completed syndrome set downstream through a one-deep output buffer with valid/ready, so the next codeword can accumulate meanwhile.

---
 rtl/rs_syndrome_calc.sv | 70 +++++++
 tb/tb_rs_syndrome_calc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: serial Horner-rule syndrome evaluator over GF(2^5) with a one-deep valid/ready output buffer
module rs_syndrome_calc #(
    parameter int N    = 31,
    parameter int NSYN = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [4:0]        sym_in,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic [5*NSYN-1:0] syn_out,
    output logic              syn_valid,
    input  logic              syn_ready,
    output logic              err_flag
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [4:0] ALPHA [8] = '{5'd2, 5'd4, 5'd8, 5'd16, 5'd5, 5'd10, 5'd20, 5'd13};

    // shift-and-add multiply reduced by x^5 = x^2 + 1; constant b collapses to an XOR network
    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] p;
        logic [4:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 5; i++) begin
            p = p ^ (b[i] ? x : 5'd0);
            x = {x[3:0], 1'b0} ^ (x[4] ? 5'b00101 : 5'b00000);
        end
        return p;
    endfunction

    logic [CW-1:0]     sym_cnt;
    logic [5*NSYN-1:0] acc;
    logic [5*NSYN-1:0] acc_nxt;
    logic              accept;
    logic              load;

    assign sym_ready = !flush && !(sym_cnt == LAST && syn_valid && !syn_ready);
    assign accept    = sym_valid && sym_ready;
    assign load      = accept && sym_cnt == LAST;

    for (genvar j = 0; j < NSYN; j++) begin : g_syn
        assign acc_nxt[5*j +: 5] = (sym_cnt == '0) ? sym_in : gf_mul(acc[5*j +: 5], ALPHA[j]) ^ sym_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt   <= '0;
            acc       <= '0;
            syn_out   <= '0;
            syn_valid <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            if (flush) begin
                sym_cnt <= '0;
                acc     <= '0;
            end else if (accept) begin
                sym_cnt <= load ? '0 : sym_cnt + CW'(1);
                acc     <= acc_nxt;
            end
            if (load) begin
                syn_out  <= acc_nxt;
                err_flag <= |acc_nxt;
            end
            syn_valid <= load || (syn_valid && !syn_ready);
        end
    end
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb_rs_syndrome_calc: table vectors, random codewords vs. a log/antilog polynomial-evaluation model, handshake corners
module tb_rs_syndrome_calc;
    localparam int N    = 31;
    localparam int NSYN = 4;

    typedef logic [4:0] cw_t [N];
    typedef struct {
        int                pos;
        logic [4:0]        val;
        logic [5*NSYN-1:0] syn;
        logic              err;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [4:0]        sym_in;
    logic              sym_valid;
    logic              sym_ready;
    logic [5*NSYN-1:0] syn_out;
    logic              syn_valid;
    logic              syn_ready;
    logic              err_flag;

    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    logic pre_valid;
    int   exp_t [31];
    int   log_t [32];
    vec_t tbl [4];
    cw_t  cw, cwa, cwb;
    logic [5*NSYN-1:0] syn_a, syn_b, s_exp;

    rs_syndrome_calc #(.N(N), .NSYN(NSYN)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .sym_in(sym_in),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .syn_out(syn_out),
        .syn_valid(syn_valid), .syn_ready(syn_ready), .err_flag(err_flag)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // S_j = sum_i r_i * alpha^(j*i), evaluated directly with log/antilog tables
    function automatic logic [5*NSYN-1:0] model(input cw_t c);
        logic [5*NSYN-1:0] s;
        s = '0;
        for (int j = 1; j <= NSYN; j++)
            for (int i = 0; i < N; i++)
                if (c[i] != 0) s[5*(j-1) +: 5] = s[5*(j-1) +: 5] ^ 5'(exp_t[(log_t[c[i]] + j*i) % 31]);
        return s;
    endfunction

    task automatic send(input cw_t c, input int n, input bit gaps);
        int w;
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                sym_valid = 1'b0;
                sym_in = 5'($urandom);
                step();
            end
            sym_valid = 1'b1;
            sym_in = c[N-1-k];
            #0;
            w = 0;
            while (!sym_ready && w < 50) begin
                step();
                w++;
                stalls++;
            end
            if (w == 50) chk("sym_ready_wait", {31'd0, sym_ready}, 32'd1);
            pre_valid = syn_valid;
            step();
        end
        sym_valid = 1'b0;
    endtask

    task automatic check_set(input string name, input logic [5*NSYN-1:0] s);
        chk({name, "_valid"}, {31'd0, syn_valid}, 32'd1);
        chk({name, "_syn"}, 32'(syn_out), 32'(s));
        chk({name, "_err"}, {31'd0, err_flag}, {31'd0, |s});
    endtask

    function automatic cw_t one_hot(input int pos, input logic [4:0] val);
        cw_t c;
        for (int i = 0; i < N; i++) c[i] = 5'd0;
        if (pos >= 0) c[pos] = val;
        return c;
    endfunction

    function automatic cw_t rand_cw();
        cw_t c;
        for (int i = 0; i < N; i++) c[i] = 5'($urandom);
        return c;
    endfunction

    initial begin
        int v;
        exp_t[0] = 1;
        for (int k = 1; k < 31; k++) begin
            v = exp_t[k-1] * 2;
            if (v >= 32) v = v ^ 37;
            exp_t[k] = v;
        end
        log_t[0] = 0;
        for (int k = 0; k < 31; k++) log_t[exp_t[k]] = k;

        tbl[0] = '{-1, 5'd0, 20'd0, 1'b0};
        tbl[1] = '{30, 5'd1, {5'd11, 5'd22, 5'd9, 5'd18}, 1'b1};
        tbl[2] = '{1, 5'd1, {5'd16, 5'd8, 5'd4, 5'd2}, 1'b1};
        tbl[3] = '{0, 5'd7, {5'd7, 5'd7, 5'd7, 5'd7}, 1'b1};

        reset_n = 1'b0; flush = 1'b0; sym_in = 5'd0; sym_valid = 1'b0; syn_ready = 1'b1;
        #2;
        chk("rst_sym_ready", {31'd0, sym_ready}, 32'd1);
        chk("rst_syn_valid", {31'd0, syn_valid}, 32'd0);
        chk("rst_syn_out", 32'(syn_out), 32'd0);
        chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        for (int g = 0; g < 2; g++)
            for (int t = 0; t < 4; t++) begin
                cw = one_hot(tbl[t].pos, tbl[t].val);
                send(cw, N, g[0]);
                chk("tbl_pre_last_valid", {31'd0, pre_valid}, 32'd0);
                chk("tbl_syn", 32'(syn_out), 32'(tbl[t].syn));
                chk("tbl_valid", {31'd0, syn_valid}, 32'd1);
                chk("tbl_err", {31'd0, err_flag}, {31'd0, tbl[t].err});
                step();
                chk("tbl_valid_clear", {31'd0, syn_valid}, 32'd0);
            end

        for (int r = 0; r < 12; r++) begin
            cw = rand_cw();
            if (r < 3) for (int i = 0; i < N; i++) if ($urandom_range(0, 3) != 0) cw[i] = 5'd0;
            send(cw, N, 1'b1);
            check_set("rand", model(cw));
            step();
        end

        // backpressure: only the final symbol of the second codeword stalls
        syn_ready = 1'b0;
        cwa = one_hot(30, 5'd1);
        cwb = one_hot(1, 5'd1);
        syn_a = model(cwa);
        syn_b = model(cwb);
        send(cwa, N, 1'b0);
        check_set("bp_first", syn_a);
        stalls = 0;
        send(cwb, N-1, 1'b0);
        chk("bp_no_early_stall", 32'(stalls), 32'd0);
        sym_valid = 1'b1;
        sym_in = cwb[0];
        #0;
        chk("bp_last_stall", {31'd0, sym_ready}, 32'd0);
        step(); step(); step();
        chk("bp_still_stalled", {31'd0, sym_ready}, 32'd0);
        check_set("bp_hold", syn_a);
        syn_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, sym_ready}, 32'd1);
        step();
        sym_valid = 1'b0;
        check_set("bp_second", syn_b);
        step();
        chk("bp_clear", {31'd0, syn_valid}, 32'd0);

        // flush discards the partial codeword but leaves a pending result alone
        syn_ready = 1'b0;
        send(cwa, N, 1'b0);
        send(rand_cw(), 10, 1'b0);
        flush = 1'b1;
        sym_valid = 1'b1;
        sym_in = 5'($urandom_range(1, 31));
        #1;
        chk("flush_ready_low", {31'd0, sym_ready}, 32'd0);
        step();
        flush = 1'b0;
        sym_valid = 1'b0;
        check_set("flush_pending", syn_a);
        syn_ready = 1'b1;
        step();
        chk("flush_consumed", {31'd0, syn_valid}, 32'd0);
        send(cwb, N, 1'b1);
        check_set("flush_after", syn_b);
        step();

        // asynchronous reset mid-codeword with a result pending
        syn_ready = 1'b0;
        cw = rand_cw();
        cw[30] = 5'd3;
        send(cw, N, 1'b0);
        send(rand_cw(), 15, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_syn_valid", {31'd0, syn_valid}, 32'd0);
        chk("arst_syn_out", 32'(syn_out), 32'd0);
        chk("arst_err_flag", {31'd0, err_flag}, 32'd0);
        chk("arst_sym_ready", {31'd0, sym_ready}, 32'd1);
        step();
        reset_n = 1'b1;
        syn_ready = 1'b1;
        step();
        cw = rand_cw();
        s_exp = model(cw);
        send(cw, N, 1'b1);
        check_set("arst_after", s_exp);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
